// File: rtl/siftah_ctrl.sv
// -----------------------------------------------------------------------------
// siftah_ctrl -- frame-paced command sequencer for the siftah (throttle slider)
// mover.
//
// The raw plus/minus key levels become one-frame step commands, with a press
// delay and auto-repeat. After a collision the player is overridden by a forced
// drain of CRASH_FRAMES down-steps. Input then stays locked out until both keys
// are released. All state advances only on frame ticks (startOfFrame = 1). The
// only exception is the sticky collision-pending flag, which latches a
// collision on any cycle.
//
// Optional feature macro: SIFTAH_AUTOREPEAT_EN
//   defined   -> press delay plus auto-repeat (FIRST -> DELAY -> REPEAT)
//   undefined -> exactly one step per press (FIRST holds while the key is held)
//
// Parameters
//   INIT_DELAY     frames held after the first step before repeating (1..63)
//   REPEAT_PERIOD  frames between repeated steps (1..63)
//   CRASH_FRAMES   forced down-steps after a collision (1..63)
//
// Ports
//   clk             system clock
//   reset           synchronous, active-high reset
//   startOfFrame    one-cycle frame tick
//   plusIsPressed   raw key level, throttle up
//   minusIsPressed  raw key level, throttle down
//   collision       one-cycle collision pulse, any cycle
//   stepUp          registered +1 step request, high for one frame
//   stepDown        registered -1 step request, high for one frame
//   overrideActive  registered, high while in CRASH or LOCKOUT
// -----------------------------------------------------------------------------
module siftah_ctrl #(
    parameter int unsigned INIT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD = 2,
    parameter int unsigned CRASH_FRAMES  = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    input  logic plusIsPressed,
    input  logic minusIsPressed,
    input  logic collision,
    output logic stepUp,
    output logic stepDown,
    output logic overrideActive
);

`ifdef SIFTAH_AUTOREPEAT_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FIRST   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_REPEAT  = 3'd3,
        ST_CRASH   = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    localparam logic [5:0] INIT_LOAD = 6'(INIT_DELAY - 32'd1);
    localparam logic [5:0] REP_LOAD  = 6'(REPEAT_PERIOD - 32'd1);
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FIRST   = 3'd1,
        ST_CRASH   = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;
`endif

    localparam logic [5:0] CRASH_LOAD = 6'(CRASH_FRAMES - 32'd1);

    // Reject out-of-range configurations at elaboration time.
    if ((INIT_DELAY == 32'd0) || (INIT_DELAY > 32'd63) ||
        (REPEAT_PERIOD == 32'd0) || (REPEAT_PERIOD > 32'd63) ||
        (CRASH_FRAMES == 32'd0) || (CRASH_FRAMES > 32'd63)) begin : g_cfg_err
        $error("siftah_ctrl: parameter out of range 1..63");
    end

    // dir encoding: 1'b0 = UP, 1'b1 = DN
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic       coll_pend_q, coll_pend_d;
    logic       step_up_q, step_up_d;
    logic       step_dn_q, step_dn_d;
    logic       ovr_q, ovr_d;

    logic key_up_s;
    logic key_dn_s;
    logic key_none_s;
    logic key_match_s;

    // Key decode: exactly one key pressed gives a direction; anything else is NONE.
    always_comb begin
        key_up_s    = plusIsPressed & ~minusIsPressed;
        key_dn_s    = minusIsPressed & ~plusIsPressed;
        key_none_s  = ~(key_up_s | key_dn_s);
        key_match_s = (dir_q == DIR_DN) ? key_dn_s : key_up_s;
    end

    // Next-state logic. Only frame ticks move the FSM; the pending flag collects
    // collisions between ticks.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        coll_pend_d = coll_pend_q | collision;
        step_up_d   = step_up_q;
        step_dn_d   = step_dn_q;
        ovr_d       = ovr_q;

        if (startOfFrame) begin
            coll_pend_d = 1'b0;
            step_up_d   = 1'b0;
            step_dn_d   = 1'b0;

            if (coll_pend_q || collision) begin
                // A collision wins from every state and restarts the drain.
                state_d   = ST_CRASH;
                cnt_d     = CRASH_LOAD;
                step_dn_d = 1'b1;
            end else begin
                case (state_q)
                    ST_CRASH: begin
                        // The entry tick already issued one step, so the counter
                        // holds the steps still owed. The tick that pays the last
                        // one also moves on to LOCKOUT.
                        if (cnt_q == 6'd0) begin
                            state_d = ST_LOCKOUT;
                        end else begin
                            step_dn_d = 1'b1;
                            cnt_d     = cnt_q - 6'd1;
                            if (cnt_q == 6'd1) begin
                                state_d = ST_LOCKOUT;
                            end else begin
                                state_d = ST_CRASH;
                            end
                        end
                    end
                    ST_LOCKOUT: begin
                        if (key_none_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_LOCKOUT;
                        end
                    end
                    ST_IDLE: begin
                        if (key_up_s) begin
                            state_d   = ST_FIRST;
                            dir_d     = DIR_UP;
                            step_up_d = 1'b1;
                        end else if (key_dn_s) begin
                            state_d   = ST_FIRST;
                            dir_d     = DIR_DN;
                            step_dn_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_FIRST: begin
                        if (!key_match_s) begin
                            state_d = ST_IDLE;
                        end else begin
`ifdef SIFTAH_AUTOREPEAT_EN
                            state_d = ST_DELAY;
                            cnt_d   = INIT_LOAD;
`else
                            state_d = ST_FIRST;
`endif
                        end
                    end
`ifdef SIFTAH_AUTOREPEAT_EN
                    ST_DELAY: begin
                        if (!key_match_s) begin
                            state_d = ST_IDLE;
                        end else if (cnt_q == 6'd0) begin
                            state_d   = ST_REPEAT;
                            cnt_d     = REP_LOAD;
                            step_up_d = (dir_q == DIR_UP);
                            step_dn_d = (dir_q == DIR_DN);
                        end else begin
                            cnt_d = cnt_q - 6'd1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!key_match_s) begin
                            state_d = ST_IDLE;
                        end else if (cnt_q == 6'd0) begin
                            cnt_d     = REP_LOAD;
                            step_up_d = (dir_q == DIR_UP);
                            step_dn_d = (dir_q == DIR_DN);
                        end else begin
                            cnt_d = cnt_q - 6'd1;
                        end
                    end
`endif
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            ovr_d = (state_d == ST_CRASH) || (state_d == ST_LOCKOUT);
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 6'd0;
            dir_q       <= DIR_UP;
            coll_pend_q <= 1'b0;
            step_up_q   <= 1'b0;
            step_dn_q   <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            coll_pend_q <= coll_pend_d;
            step_up_q   <= step_up_d;
            step_dn_q   <= step_dn_d;
            ovr_q       <= ovr_d;
        end
    end

    assign stepUp         = step_up_q;
    assign stepDown       = step_dn_q;
    assign overrideActive = ovr_q;

endmodule

// File: tb/tb_siftah_ctrl.sv
module tb_siftah_ctrl;

    localparam int ID = 8;
    localparam int RP = 2;
    localparam int CF = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sof = 1'b0;
    logic plus = 1'b0;
    logic minus = 1'b0;
    logic coll = 1'b0;
    logic step_up, step_dn, ovr;

    int checks = 0;
    int errors = 0;
    int n_up = 0;
    int n_dn = 0;

    siftah_ctrl #(
        .INIT_DELAY(ID),
        .REPEAT_PERIOD(RP),
        .CRASH_FRAMES(CF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .startOfFrame(sof),
        .plusIsPressed(plus),
        .minusIsPressed(minus),
        .collision(coll),
        .stepUp(step_up),
        .stepDown(step_dn),
        .overrideActive(ovr)
    );

    always #5 clk = ~clk;

    // Behavioural reference: the player is idle, holding a key (age = frames
    // since the press), being drained after a crash, or locked out.
    typedef enum int {M_IDLE, M_HELD, M_CRASH, M_LOCK} mmode_t;
    mmode_t m_mode;
    int     m_dir;   // 1 = up, 2 = down
    int     m_age;
    int     m_left;  // down-steps still owed
    bit     m_pend;
    bit     e_up, e_dn, e_ovr;

    function automatic int decode(bit p, bit m);
        if (p && !m) return 1;
        if (m && !p) return 2;
        return 0;
    endfunction

    function automatic bit repeat_due(int age);
`ifdef SIFTAH_AUTOREPEAT_EN
        return (age >= ID + 1) && (((age - ID - 1) % RP) == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_dir = 1; m_age = 0; m_left = 0; m_pend = 1'b0;
        e_up = 1'b0; e_dn = 1'b0; e_ovr = 1'b0;
    endtask

    task automatic model_tick(input bit p, input bit m, input bit coll_now);
        int k;
        k = decode(p, m);
        e_up = 1'b0;
        e_dn = 1'b0;
        if (m_pend || coll_now) begin
            m_mode = M_CRASH;
            m_left = CF - 1;
            e_dn = 1'b1;
        end else begin
            case (m_mode)
                M_CRASH: begin
                    if (m_left == 0) m_mode = M_LOCK;
                    else begin
                        e_dn = 1'b1;
                        m_left--;
                        if (m_left == 0) m_mode = M_LOCK;
                    end
                end
                M_LOCK: if (k == 0) m_mode = M_IDLE;
                M_IDLE: begin
                    if (k != 0) begin
                        m_mode = M_HELD; m_dir = k; m_age = 0;
                        e_up = (k == 1); e_dn = (k == 2);
                    end
                end
                default: begin
                    if (k != m_dir) m_mode = M_IDLE;
                    else begin
                        m_age++;
                        if (repeat_due(m_age)) begin
                            e_up = (m_dir == 1); e_dn = (m_dir == 2);
                        end
                    end
                end
            endcase
        end
        m_pend = 1'b0;
        e_ovr = (m_mode == M_CRASH) || (m_mode == M_LOCK);
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".stepUp"}, step_up, e_up);
        check({tag, ".stepDown"}, step_dn, e_dn);
        check({tag, ".overrideActive"}, ovr, e_ovr);
    endtask

    // One frame: a tick cycle followed by three non-tick cycles. A mid-frame
    // collision is pulsed on the first non-tick cycle.
    task automatic frame(input bit p, input bit m, input bit coll_tick, input bit coll_mid,
                         input string tag);
        @(negedge clk);
        plus = p; minus = m; sof = 1'b1; coll = coll_tick;
        @(posedge clk);
        model_tick(p, m, coll_tick);
        @(negedge clk);
        sof = 1'b0; coll = coll_mid;
        if (coll_mid) m_pend = 1'b1;
        check_outs(tag);
        if (step_up === 1'b1) n_up++;
        if (step_dn === 1'b1) n_dn++;
        @(negedge clk);
        coll = 1'b0;
        check_outs({tag, "_hold"});
        @(negedge clk);
    endtask

    // Reset asserted together with a tick and a collision; reset must win.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1; sof = 1'b1; coll = 1'b1; plus = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; sof = 1'b0; coll = 1'b0; plus = 1'b0;
        model_reset();
        check({tag, ".stepUp"}, step_up, 1'b0);
        check({tag, ".stepDown"}, step_dn, 1'b0);
        check({tag, ".overrideActive"}, ovr, 1'b0);
    endtask

    initial begin
        bit kp, km, ct, cm;
        bit exp_up_tick;

        model_reset();
        do_reset("reset");

        // Plus held for 14 ticks.
        n_up = 0; n_dn = 0;
        for (int i = 0; i < 14; i++) begin
            frame(1'b1, 1'b0, 1'b0, 1'b0, "hold_plus");
`ifdef SIFTAH_AUTOREPEAT_EN
            exp_up_tick = (i == 0) || (i == 9) || (i == 11) || (i == 13);
`else
            exp_up_tick = (i == 0);
`endif
            check("hold_plus_tick", step_up, exp_up_tick);
        end
`ifdef SIFTAH_AUTOREPEAT_EN
        check("hold_plus_count", n_up == 4, 1'b1);
`else
        check("hold_plus_count", n_up == 1, 1'b1);
`endif
        check("hold_plus_no_down", n_dn == 0, 1'b1);
        frame(1'b0, 1'b0, 1'b0, 1'b0, "release");

        // Both keys held: NONE, no steps.
        n_up = 0; n_dn = 0;
        for (int i = 0; i < 10; i++) frame(1'b1, 1'b1, 1'b0, 1'b0, "both");
        check("both_no_steps", (n_up + n_dn) == 0, 1'b1);

        // Minus held, then plus from tick 5.
        n_up = 0; n_dn = 0;
        for (int i = 0; i < 5; i++) frame(1'b0, 1'b1, 1'b0, 1'b0, "minus");
        frame(1'b1, 1'b0, 1'b0, 1'b0, "switch_t5");
        check("switch_t5_idle", step_up | step_dn, 1'b0);
        frame(1'b1, 1'b0, 1'b0, 1'b0, "switch_t6");
        check("switch_t6_up", step_up, 1'b1);
        check("switch_counts", (n_dn == 1) && (n_up == 1), 1'b1);
        frame(1'b0, 1'b0, 1'b0, 1'b0, "release2");

        // Collision mid-frame with plus held; drain, lockout, release, re-press.
        frame(1'b1, 1'b0, 1'b0, 1'b1, "press_coll");
        n_up = 0; n_dn = 0;
        for (int i = 0; i < 20; i++) begin
            frame(1'b1, 1'b0, 1'b0, 1'b0, "crash");
            check("crash_down", step_dn, 1'b1);
            check("crash_ovr", ovr, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            frame(1'b1, 1'b0, 1'b0, 1'b0, "lockout");
            check("lockout_ovr", ovr, 1'b1);
        end
        check("crash_count", (n_dn == 20) && (n_up == 0), 1'b1);
        frame(1'b0, 1'b0, 1'b0, 1'b0, "unlock");
        check("unlock_ovr", ovr, 1'b0);
        frame(1'b1, 1'b0, 1'b0, 1'b0, "repress");
        check("repress_up", step_up, 1'b1);
        frame(1'b0, 1'b0, 1'b0, 1'b0, "release3");

        // Second collision on tick 10 of CRASH reloads the drain.
        frame(1'b0, 1'b0, 1'b0, 1'b1, "coll_idle");
        n_up = 0; n_dn = 0;
        for (int j = 0; j < 35; j++) frame(1'b0, 1'b0, (j == 10), 1'b0, "recrash");
        check("recrash_count", n_dn == 30, 1'b1);

        // Randomised run against the model.
        kp = 1'b0; km = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                kp = 1'($urandom_range(0, 1));
                km = 1'($urandom_range(0, 1));
            end
            ct = ($urandom_range(0, 59) == 0);
            cm = ($urandom_range(0, 59) == 1);
            frame(kp, km, ct, cm, "random");
        end
        frame(1'b0, 1'b0, 1'b0, 1'b0, "rand_end");
        for (int i = 0; i < 25; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, "drain");

        // Reset in the middle of a held press (REPEAT when auto-repeat exists).
        for (int i = 0; i < 12; i++) frame(1'b1, 1'b0, 1'b0, 1'b0, "pre_reset");
        do_reset("reset_repeat");
        n_up = 0; n_dn = 0;
        for (int i = 0; i < 20; i++) frame(1'b1, 1'b0, 1'b0, 1'b0, "hold20");
`ifdef SIFTAH_AUTOREPEAT_EN
        check("hold20_count", n_up == 7, 1'b1);
`else
        check("hold20_count", n_up == 1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
